// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, variable-latency IMem req/ack port, IF/ID register, one-entry hold buffer.
// Optional build macro IF_DELAY_SLOT_EN: deliver the post-branch instruction as a delay slot instead of squashing it.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_pc_write,
    input  logic        i_if_id_write,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_data,
    output logic [31:0] o_if_id_pc,
    output logic [31:0] o_if_id_pc_plus4,
    output logic [31:0] o_if_id_instr,
    output logic        o_if_id_valid,
    output logic        o_fetch_stall
);

`ifdef IF_DELAY_SLOT_EN
    localparam logic DS_EN = 1'b1;
`else
    localparam logic DS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_REDIR_WAIT} state_t;

    state_t      r_state, w_state_n;
    logic [31:0] r_pc, w_pc_n;
    logic [31:0] r_ifid_pc, w_ifid_pc_n;
    logic [31:0] r_ifid_pc4, w_ifid_pc4_n;
    logic [31:0] r_ifid_instr, w_ifid_instr_n;
    logic        r_ifid_valid, w_ifid_valid_n;
    logic [31:0] r_hold_buf, w_hold_buf_n;
    logic [31:0] r_pend_tgt, w_pend_tgt_n;
    logic        r_hold_redir, w_hold_redir_n;

    logic        w_stalled, w_req, w_ack;
    logic [31:0] w_pc4;
    logic        w_deliver, w_slot, w_bubble;
    logic [31:0] w_deliver_instr;

    assign w_stalled = !i_pc_write || !i_if_id_write;
    // Request is gated by rst_n so nothing is presented while reset is held.
    assign w_req     = rst_n && (r_state != S_HOLD);
    assign w_ack     = w_req && i_imem_ack;
    assign w_pc4     = r_pc + 32'd4;

    always_comb begin
        w_state_n       = r_state;
        w_pc_n          = r_pc;
        w_hold_buf_n    = r_hold_buf;
        w_pend_tgt_n    = r_pend_tgt;
        w_hold_redir_n  = r_hold_redir;
        w_deliver       = 1'b0;
        w_slot          = 1'b0;
        w_bubble        = 1'b0;
        w_deliver_instr = i_imem_data;

        case (r_state)
            S_FETCH: begin
                if (w_ack && !w_stalled) begin
                    w_deliver = 1'b1;
                    w_slot    = i_redirect;
                    w_pc_n    = i_redirect ? i_redirect_pc : w_pc4;
                end else if (w_ack) begin
                    w_hold_buf_n   = i_imem_data;
                    w_hold_redir_n = 1'b0;
                    w_state_n      = S_HOLD;
                end else if (!w_stalled) begin
                    w_bubble = 1'b1;
                    if (i_redirect) begin
                        w_pend_tgt_n = i_redirect_pc;
                        w_state_n    = S_REDIR_WAIT;
                    end
                end
            end
            S_HOLD: begin
                if (!w_stalled) begin
                    w_deliver       = 1'b1;
                    w_deliver_instr = r_hold_buf;
                    w_state_n       = S_FETCH;
                    // A buffer filled in REDIR_WAIT already owes its branch target.
                    if (r_hold_redir) begin
                        w_slot = 1'b1;
                        w_pc_n = r_pend_tgt;
                    end else begin
                        w_slot = i_redirect;
                        w_pc_n = i_redirect ? i_redirect_pc : w_pc4;
                    end
                end
            end
            S_REDIR_WAIT: begin
                if (w_ack && !w_stalled) begin
                    w_deliver = 1'b1;
                    w_slot    = 1'b1;
                    w_pc_n    = r_pend_tgt;
                    w_state_n = S_FETCH;
                end else if (w_ack) begin
                    w_hold_buf_n   = i_imem_data;
                    w_hold_redir_n = 1'b1;
                    w_state_n      = S_HOLD;
                end else if (!w_stalled) begin
                    w_bubble = 1'b1;
                end
            end
            default: w_state_n = S_FETCH;
        endcase

        w_ifid_pc_n    = r_ifid_pc;
        w_ifid_pc4_n   = r_ifid_pc4;
        w_ifid_instr_n = r_ifid_instr;
        w_ifid_valid_n = r_ifid_valid;
        if (w_deliver && (!w_slot || DS_EN)) begin
            w_ifid_pc_n    = r_pc;
            w_ifid_pc4_n   = w_pc4;
            w_ifid_instr_n = w_deliver_instr;
            w_ifid_valid_n = 1'b1;
        end else if (w_deliver || w_bubble) begin
            w_ifid_instr_n = 32'h0;
            w_ifid_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_ifid_pc    <= 32'h0;
            r_ifid_pc4   <= 32'h0;
            r_ifid_instr <= 32'h0;
            r_ifid_valid <= 1'b0;
            r_hold_buf   <= 32'h0;
            r_pend_tgt   <= 32'h0;
            r_hold_redir <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_pc         <= w_pc_n;
            r_ifid_pc    <= w_ifid_pc_n;
            r_ifid_pc4   <= w_ifid_pc4_n;
            r_ifid_instr <= w_ifid_instr_n;
            r_ifid_valid <= w_ifid_valid_n;
            r_hold_buf   <= w_hold_buf_n;
            r_pend_tgt   <= w_pend_tgt_n;
            r_hold_redir <= w_hold_redir_n;
        end
    end

    assign o_imem_req       = w_req;
    assign o_imem_addr      = r_pc;
    assign o_fetch_stall    = w_req && !i_imem_ack;
    assign o_if_id_pc       = r_ifid_pc;
    assign o_if_id_pc_plus4 = r_ifid_pc4;
    assign o_if_id_instr    = r_ifid_instr;
    assign o_if_id_valid    = r_ifid_valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; memory returns (address ^ K) so the expected instruction word follows from the PC.
module tb_if_stage;
    localparam logic [31:0] K = 32'hA500_0000;
`ifdef IF_DELAY_SLOT_EN
    localparam logic DS = 1'b1;
`else
    localparam logic DS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_pc_write, i_if_id_write, i_redirect, i_imem_ack;
    logic [31:0] i_redirect_pc, i_imem_data;
    logic        o_imem_req, o_if_id_valid, o_fetch_stall;
    logic [31:0] o_imem_addr, o_if_id_pc, o_if_id_pc_plus4, o_if_id_instr;

    int n_pass = 0;
    int n_total = 0;

    if_stage #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_pc_write(i_pc_write), .i_if_id_write(i_if_id_write),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_ack(i_imem_ack), .i_imem_data(i_imem_data),
        .o_if_id_pc(o_if_id_pc), .o_if_id_pc_plus4(o_if_id_pc_plus4),
        .o_if_id_instr(o_if_id_instr), .o_if_id_valid(o_if_id_valid),
        .o_fetch_stall(o_fetch_stall)
    );

    always #5 clk = ~clk;
    always_comb i_imem_data = o_imem_addr ^ K;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_pc_write = 1'b1; i_if_id_write = 1'b1;
        i_redirect = 1'b0; i_redirect_pc = 32'h0; i_imem_ack = 1'b1;
        tick(); tick();
        n_total++; if (o_imem_req !== 1'b0) $display("FAIL reset_req got %b want 0", o_imem_req); else n_pass++;
        n_total++; if (o_if_id_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", o_if_id_valid); else n_pass++;
        n_total++; if ({o_if_id_pc, o_if_id_instr} !== 64'h0) $display("FAIL reset_ifid got %h/%h want 0/0", o_if_id_pc, o_if_id_instr); else n_pass++;
        i_imem_ack = 1'b0;
        rst_n = 1'b1;
        #1;
        n_total++; if ({o_imem_req, o_imem_addr} !== {1'b1, 32'h0}) $display("FAIL first_req got %b/%h want 1/0", o_imem_req, o_imem_addr); else n_pass++;
    endtask

    task automatic test_zero_wait();
        logic [31:0] pc;
        i_imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc = 32'(i * 4);
            n_total++; if (o_imem_addr !== pc) $display("FAIL zw_addr got %h want %h", o_imem_addr, pc); else n_pass++;
            tick();
            n_total++; if ({o_if_id_pc, o_if_id_pc_plus4, o_if_id_instr, o_if_id_valid} !== {pc, pc + 32'd4, pc ^ K, 1'b1})
                $display("FAIL zw_ifid got %h/%h/%h/%b want %h/%h/%h/1", o_if_id_pc, o_if_id_pc_plus4, o_if_id_instr, o_if_id_valid, pc, pc + 32'd4, pc ^ K);
            else n_pass++;
        end
    endtask

    task automatic test_stall_hold();
        // PC=0x10: ack arrives while the hazard unit stalls
        i_imem_ack = 1'b1; i_pc_write = 1'b0; i_if_id_write = 1'b0;
        tick();
        n_total++; if ({o_imem_req, o_fetch_stall} !== 2'b00) $display("FAIL hold_req got %b/%b want 0/0", o_imem_req, o_fetch_stall); else n_pass++;
        tick(); tick();
        n_total++; if ({o_if_id_pc, o_if_id_valid} !== {32'hC, 1'b1}) $display("FAIL hold_ifid got %h/%b want c/1", o_if_id_pc, o_if_id_valid); else n_pass++;
        i_pc_write = 1'b1; i_if_id_write = 1'b1; i_imem_ack = 1'b0;
        tick();
        n_total++; if ({o_if_id_pc, o_if_id_instr, o_if_id_valid} !== {32'h10, 32'h10 ^ K, 1'b1})
            $display("FAIL hold_release got %h/%h/%b want 10/%h/1", o_if_id_pc, o_if_id_instr, o_if_id_valid, 32'h10 ^ K);
        else n_pass++;
        n_total++; if ({o_imem_req, o_imem_addr} !== {1'b1, 32'h14}) $display("FAIL hold_next_addr got %b/%h want 1/14", o_imem_req, o_imem_addr); else n_pass++;
    endtask

    task automatic test_latency();
        i_imem_ack = 1'b0;
        #1;
        n_total++; if (o_fetch_stall !== 1'b1) $display("FAIL lat_fetch_stall got %b want 1", o_fetch_stall); else n_pass++;
        tick();
        n_total++; if ({o_if_id_pc, o_if_id_instr, o_if_id_valid} !== {32'h10, 32'h0, 1'b0})
            $display("FAIL lat_bubble got %h/%h/%b want 10/0/0", o_if_id_pc, o_if_id_instr, o_if_id_valid);
        else n_pass++;
        i_imem_ack = 1'b1;
        #1;
        n_total++; if (o_fetch_stall !== 1'b0) $display("FAIL lat_ack_stall got %b want 0", o_fetch_stall); else n_pass++;
        tick();
        n_total++; if ({o_if_id_pc, o_if_id_valid} !== {32'h14, 1'b1}) $display("FAIL lat_deliver got %h/%b want 14/1", o_if_id_pc, o_if_id_valid); else n_pass++;
        tick(); tick();
    endtask

    task automatic test_redirect_ack();
        // PC=0x20 now
        i_imem_ack = 1'b1; i_redirect = 1'b1; i_redirect_pc = 32'h100;
        tick();
        i_redirect = 1'b0;
        n_total++; if (o_imem_addr !== 32'h100) $display("FAIL rda_addr got %h want 100", o_imem_addr); else n_pass++;
        n_total++; if ({o_if_id_valid, o_if_id_instr} !== (DS ? {1'b1, 32'h20 ^ K} : 33'h0))
            $display("FAIL rda_slot got %b/%h want %b", o_if_id_valid, o_if_id_instr, DS);
        else n_pass++;
        tick();
        n_total++; if ({o_if_id_pc, o_if_id_valid, o_imem_addr} !== {32'h100, 1'b1, 32'h104})
            $display("FAIL rda_target got %h/%b/%h want 100/1/104", o_if_id_pc, o_if_id_valid, o_imem_addr);
        else n_pass++;
    endtask

    task automatic test_redirect_wait();
        i_redirect = 1'b1; i_redirect_pc = 32'h40;
        tick();
        i_imem_ack = 1'b0; i_redirect_pc = 32'h200;
        tick();
        n_total++; if ({o_imem_addr, o_if_id_valid, o_if_id_instr} !== {32'h40, 1'b0, 32'h0})
            $display("FAIL rdw_bubble got %h/%b/%h want 40/0/0", o_imem_addr, o_if_id_valid, o_if_id_instr);
        else n_pass++;
        i_redirect_pc = 32'h300;
        tick();
        n_total++; if ({o_imem_addr, o_fetch_stall} !== {32'h40, 1'b1}) $display("FAIL rdw_addr_stable got %h/%b want 40/1", o_imem_addr, o_fetch_stall); else n_pass++;
        i_redirect = 1'b0; i_imem_ack = 1'b1;
        tick();
        n_total++; if (o_imem_addr !== 32'h200) $display("FAIL rdw_target got %h want 200", o_imem_addr); else n_pass++;
        n_total++; if ({o_if_id_valid, o_if_id_instr} !== (DS ? {1'b1, 32'h40 ^ K} : 33'h0))
            $display("FAIL rdw_slot got %b/%h want %b", o_if_id_valid, o_if_id_instr, DS);
        else n_pass++;
        tick();
        n_total++; if ({o_if_id_pc, o_if_id_valid} !== {32'h200, 1'b1}) $display("FAIL rdw_deliver got %h/%b want 200/1", o_if_id_pc, o_if_id_valid); else n_pass++;
    endtask

    task automatic test_reset_in_redir();
        // PC=0x204, redirect with no ack enters REDIR_WAIT
        i_imem_ack = 1'b0; i_redirect = 1'b1; i_redirect_pc = 32'h300;
        tick();
        i_redirect = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if ({o_imem_req, o_if_id_valid, o_imem_addr} !== {1'b0, 1'b0, 32'h0})
            $display("FAIL rst_mid got %b/%b/%h want 0/0/0", o_imem_req, o_if_id_valid, o_imem_addr);
        else n_pass++;
        i_imem_ack = 1'b1;
        tick(); tick();
        n_total++; if ({o_if_id_valid, o_if_id_pc} !== 33'h0) $display("FAIL rst_stale_ack got %b/%h want 0/0", o_if_id_valid, o_if_id_pc); else n_pass++;
        rst_n = 1'b1;
        tick();
        n_total++; if ({o_if_id_pc, o_if_id_instr, o_if_id_valid, o_imem_addr} !== {32'h0, K, 1'b1, 32'h4})
            $display("FAIL rst_refetch got %h/%h/%b/%h want 0/%h/1/4", o_if_id_pc, o_if_id_instr, o_if_id_valid, o_imem_addr, K);
        else n_pass++;
    endtask

    task automatic test_wrap();
        i_imem_ack = 1'b1; i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
        tick();
        i_redirect = 1'b0;
        tick();
        n_total++; if ({o_if_id_pc, o_if_id_pc_plus4, o_imem_addr} !== {32'hFFFF_FFFC, 32'h0, 32'h0})
            $display("FAIL wrap got %h/%h/%h want fffffffc/0/0", o_if_id_pc, o_if_id_pc_plus4, o_imem_addr);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall_hold();
        test_latency();
        test_redirect_ack();
        test_redirect_wait();
        test_reset_in_redir();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline: owns the PC register, drives a variable-latency instruction-memory request/acknowledge port, and writes the IF/ID pipeline register. It sits directly upstream of the ID stage and consumes the hazard unit's PCWrite/IF_ID_Write stall controls and the ID stage's branch/jump redirect. A one-entry hold buffer absorbs instructions that return while the pipeline is stalled.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- PCWrite  in  1  hazard unit; 0 freezes PC.
- IF_ID_Write  in  1  hazard unit; 0 freezes IF/ID register.
- Redirect  in  1  ID stage: taken branch/jump/JR this cycle; sampled only when PCWrite=1.
- RedirectPC  in  32  branch/jump target, valid with Redirect.
- IMemReq  out  1  instruction fetch request.
- IMemAddr  out  32  fetch address (word aligned); stable while IMemReq=1 and IMemAck=0.
- IMemAck  in  1  instruction returned this cycle; ignored when IMemReq=0.
- IMemData  in  32  instruction word, valid with IMemAck.
- IF_ID_PC  out  32  PC of instruction in IF/ID.
- IF_ID_PCPlus4  out  32  IF_ID_PC + 4.
- IF_ID_Instr  out  32  instruction word; 32'h0 (nop) for a bubble.
- IF_ID_Valid  out  1  IF/ID holds a real instruction.
- FetchStall  out  1  fetch waiting on memory.

## Operation
- Stalled = !PCWrite || !IF_ID_Write (hazard unit drives them together; either low stalls).
- States: FETCH, HOLD, REDIR_WAIT. Reset state FETCH.
- FETCH: IMemReq=1, IMemAddr=PC.
  - Ack, not stalled: IF/ID <= {PC, PC+4, IMemData, 1}; PC <= Redirect ? RedirectPC : PC+4 (see Configuration for Redirect squash). Stay FETCH.
  - Ack, stalled: hold buffer <= IMemData; PC, IF/ID unchanged; go HOLD.
  - No ack, not stalled, Redirect=1: PendTgt <= RedirectPC; IF/ID <= bubble; go REDIR_WAIT.
  - No ack, not stalled, no Redirect: IF/ID <= bubble (Valid=0, Instr=0, PC fields unchanged).
  - No ack, stalled: nothing changes.
- HOLD: IMemReq=0. When not stalled: IF/ID <= {PC, PC+4, hold buffer, 1}; PC <= Redirect ? RedirectPC : PC+4; go FETCH. While stalled: hold.
- REDIR_WAIT: IMemReq=1, IMemAddr=PC (old address, must complete). On ack: returning instruction is the post-branch instruction; PC <= PendTgt; go FETCH (if stalled, hold buffer captures it and go HOLD with PC <= PendTgt only after HOLD exit). Redirect ignored in this state.
- FetchStall = IMemReq && !IMemAck.
- PC arithmetic 32-bit, wraps 32'hFFFF_FFFC -> 0.

## Timing
- Reset (async, rst_n=0): PC=RESET_PC, state FETCH, IF/ID all zero, Valid=0, hold buffer and PendTgt zero; IMemReq=0 while rst_n=0.
- First request issued in first cycle after rst_n rises, address RESET_PC.
- Zero-wait memory (ack same cycle as req): one instruction per cycle, fetch-to-IF/ID latency 1 cycle.
- Stall during ack: no instruction lost; delivered the cycle stall releases, no refetch.
- Redirect with ack same cycle in FETCH: handled directly, no REDIR_WAIT.
- Reset asserted mid-request or in HOLD: state, buffer, and PendTgt discarded immediately; any later IMemAck ignored until IMemReq reasserts.

## Configuration
- IF_DELAY_SLOT_EN defined: instruction following a branch (the one fetched in the Redirect cycle, the held one on HOLD exit, or the one returned in REDIR_WAIT) is the delay slot and is delivered to IF/ID with Valid=1.
- Not defined: that instruction is squashed — IF/ID loaded with bubble (Valid=0, Instr=0) instead; PC update identical.

## Test plan
- Reset, zero-wait memory returning PC-as-data -> IF_ID_PC sequence 0,4,8,12, Valid=1 every cycle from cycle 2.
- Ack at PC=8 with PCWrite=IF_ID_Write=0 for 3 cycles -> state HOLD, IMemReq=0, IF/ID keeps PC=4; on release IF_ID_PC=8, Instr=captured word, next IMemAddr=12.
- 2-cycle memory latency, not stalled -> FetchStall=1 and bubble (Valid=0, Instr=0) inserted between real instructions.
- Redirect to 0x100 at PC=0x20 with ack same cycle -> next IMemAddr=0x100; with IF_DELAY_SLOT_EN IF_ID_PC=0x20 Valid=1, without Valid=0.
- Redirect to 0x200 while request for 0x40 outstanding -> IMemAddr stays 0x40 until ack, then 0x200; 0x40 instruction delivered/squashed per macro.
- rst_n low while in REDIR_WAIT -> PC=RESET_PC, Valid=0, stale ack ignored, refetch from RESET_PC.
